// File: rtl/store_align_unit.sv
// rtl/store_align_unit.sv - store-side byte-lane aligner with byte enables and word-crossing split
module store_align_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        done,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_mem_valid;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_hi_wdata;
  logic [3:0]  r_hi_be;

  logic        w_accept;
  logic        w_illegal;
  logic        w_beat_hs;
  logic [31:0] w_data_masked;
  logic [3:0]  w_be_base;
  logic [63:0] w_w64;
  logic [7:0]  w_be8;

  assign req_ready = (r_state == IDLE) && !reset;
  assign w_accept  = req_valid && req_ready;
  assign w_illegal = (req_size == 2'b11);
  assign w_beat_hs = r_mem_valid && mem_ready;

  always_comb begin
    w_data_masked = 32'h0;
    w_be_base     = 4'b0000;
    case (req_size)
      2'b00: begin
        w_data_masked = {24'h0, req_data[7:0]};
        w_be_base     = 4'b0001;
      end
      2'b01: begin
        w_data_masked = {16'h0, req_data[15:0]};
        w_be_base     = 4'b0011;
      end
      2'b10: begin
        w_data_masked = req_data;
        w_be_base     = 4'b1111;
      end
      default: begin
        w_data_masked = 32'h0;
        w_be_base     = 4'b0000;
      end
    endcase
  end

  // Upper halves of the 64-bit lane image become beat 1 when the store crosses a word.
  assign w_w64 = {32'h0, w_data_masked} << {req_addr[1:0], 3'b000};
  assign w_be8 = {4'h0, w_be_base} << req_addr[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && !w_illegal) w_next = BEAT0;
      BEAT0:   if (w_beat_hs) w_next = (r_hi_be != 4'h0) ? BEAT1 : IDLE;
      BEAT1:   if (w_beat_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_valid <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_mem_be    <= 4'h0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_hi_wdata  <= 32'h0;
      r_hi_be     <= 4'h0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept && w_illegal) begin
            r_err <= 1'b1;
          end else if (w_accept) begin
            r_mem_valid <= 1'b1;
            r_mem_addr  <= {req_addr[31:2], 2'b00};
            r_mem_wdata <= w_w64[31:0];
            r_mem_be    <= w_be8[3:0];
            r_hi_wdata  <= w_w64[63:32];
            r_hi_be     <= w_be8[7:4];
          end
        end
        BEAT0: begin
          if (w_beat_hs && (r_hi_be != 4'h0)) begin
            r_mem_addr  <= r_mem_addr + 32'd4;
            r_mem_wdata <= r_hi_wdata;
            r_mem_be    <= r_hi_be;
          end else if (w_beat_hs) begin
            r_mem_valid <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_mem_be    <= 4'h0;
            r_done      <= 1'b1;
          end
        end
        BEAT1: begin
          if (w_beat_hs) begin
            r_mem_valid <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_mem_be    <= 4'h0;
            r_done      <= 1'b1;
          end
        end
        default: r_mem_valid <= 1'b0;
      endcase
    end
  end

  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
  assign done      = r_done;
  assign err       = r_err;
endmodule

// File: tb/tb_store_align_unit.sv
// tb/tb_store_align_unit.sv - randomized and directed bench for store_align_unit against a byte-level model
module tb_store_align_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_data = 32'h0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        done;
  logic        err;

  int nvec = 0;
  int nfail = 0;

  logic [67:0] obs_q[$];
  logic [67:0] exp_q[$];
  int done_cyc, err_cnt, wait_cyc, first_beat_cyc;
  bit stable_ok, rdy_low_ok, rdy_at_done;

  store_align_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size), .req_data(req_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Byte-at-a-time reference: each byte goes to address a+k; consecutive bytes sharing a word form one beat.
  task automatic model(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    int n;
    logic [31:0] ba;
    logic [31:0] wa;
    logic [67:0] e;
    exp_q.delete();
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int k = 0; k < n; k++) begin
      ba = a + k;
      wa = {ba[31:2], 2'b00};
      if (exp_q.size() == 0 || exp_q[exp_q.size()-1][67:36] != wa)
        exp_q.push_back({wa, 32'h0, 4'h0});
      e = exp_q[exp_q.size()-1];
      e[35:4] = e[35:4] | ({24'h0, d[8*k +: 8]} << (8 * ba[1:0]));
      e[ba[1:0]] = 1'b1;
      exp_q[exp_q.size()-1] = e;
    end
  endtask

  // Drives one request and records what the DUT emits; stall holds mem_ready low on beat 0.
  task automatic run_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                           input int stall, input bit inject);
    int cyc;
    int st;
    bit held;
    logic [67:0] hv;
    obs_q.delete();
    done_cyc = -1; err_cnt = 0; wait_cyc = 0; first_beat_cyc = -1;
    stable_ok = 1; rdy_low_ok = 1; rdy_at_done = 0; held = 0; hv = '0;
    req_valid = 1; req_addr = a; req_size = sz; req_data = d;
    while (!req_ready && wait_cyc < 20) begin
      @(posedge clk); #1; wait_cyc++;
    end
    @(posedge clk); #1;
    req_valid = 0; req_addr = $urandom; req_data = $urandom; req_size = 2'($urandom_range(0, 2));
    cyc = 1; st = stall;
    while (cyc < 40) begin
      if (done) begin
        done_cyc = cyc; rdy_at_done = req_ready;
        break;
      end
      if (err) err_cnt++;
      if (mem_valid) begin
        if (first_beat_cyc < 0) first_beat_cyc = cyc;
        if (held && hv !== {mem_addr, mem_wdata, mem_be}) stable_ok = 0;
        if (st > 0) begin
          if (!held) begin held = 1; hv = {mem_addr, mem_wdata, mem_be}; end
          if (req_ready) rdy_low_ok = 0;
          mem_ready = 0; st--;
          if (inject) begin
            req_valid = 1; req_size = 2'b10; req_addr = 32'h0000_0500; req_data = 32'hDEAD_BEEF;
          end
        end else begin
          held = 0; mem_ready = 1; req_valid = 0;
          obs_q.push_back({mem_addr, mem_wdata, mem_be});
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1; cyc++;
    end
    mem_ready = 0; req_valid = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if ({mem_valid, mem_addr, mem_wdata, mem_be, done, err} !== 71'h0) begin
      nfail++; $display("FAIL reset_outputs: got %h want 0", {mem_valid, mem_addr, mem_wdata, mem_be, done, err});
    end
    nvec++;
    if (req_ready !== 1'b0) begin nfail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    nvec++;
    if (req_ready !== 1'b1) begin nfail++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_byte();
    run_store(32'h103, 2'b00, 32'h0000_00A5, 0, 0);
    nvec++;
    if (obs_q.size() !== 1) begin nfail++; $display("FAIL byte_nbeats: got %0d want 1", obs_q.size()); end
    else begin
      nvec++;
      if (obs_q[0] !== {32'h100, 32'hA500_0000, 4'b1000}) begin
        nfail++; $display("FAIL byte_beat0: got %h want %h", obs_q[0], {32'h100, 32'hA500_0000, 4'b1000});
      end
    end
    nvec++;
    if (done_cyc !== 2 || rdy_at_done !== 1'b1) begin
      nfail++; $display("FAIL byte_done: got cycle %0d ready %b want cycle 2 ready 1", done_cyc, rdy_at_done);
    end
  endtask

  task automatic test_half();
    run_store(32'h202, 2'b01, 32'h1234_ABCD, 0, 0);
    nvec++;
    if (obs_q.size() !== 1) begin nfail++; $display("FAIL half_nbeats: got %0d want 1", obs_q.size()); end
    else begin
      nvec++;
      if (obs_q[0] !== {32'h200, 32'hABCD_0000, 4'b1100}) begin
        nfail++; $display("FAIL half_beat0: got %h want %h", obs_q[0], {32'h200, 32'hABCD_0000, 4'b1100});
      end
    end
    nvec++;
    if (done_cyc !== 2) begin nfail++; $display("FAIL half_done: got %0d want 2", done_cyc); end
  endtask

  task automatic test_misaligned_word(input int stall, input bit inject);
    run_store(32'h301, 2'b10, 32'h1122_3344, stall, inject);
    nvec++;
    if (obs_q.size() !== 2) begin nfail++; $display("FAIL mword_nbeats: got %0d want 2", obs_q.size()); end
    else begin
      nvec++;
      if (obs_q[0] !== {32'h300, 32'h2233_4400, 4'b1110}) begin
        nfail++; $display("FAIL mword_beat0: got %h want %h", obs_q[0], {32'h300, 32'h2233_4400, 4'b1110});
      end
      nvec++;
      if (obs_q[1] !== {32'h304, 32'h0000_0011, 4'b0001}) begin
        nfail++; $display("FAIL mword_beat1: got %h want %h", obs_q[1], {32'h304, 32'h0000_0011, 4'b0001});
      end
    end
    nvec++;
    if (done_cyc !== 3 + stall) begin nfail++; $display("FAIL mword_done: got %0d want %0d", done_cyc, 3 + stall); end
  endtask

  task automatic test_wrap();
    run_store(32'hFFFF_FFFF, 2'b01, 32'h0000_BEEF, 0, 0);
    nvec++;
    if (obs_q.size() !== 2) begin nfail++; $display("FAIL wrap_nbeats: got %0d want 2", obs_q.size()); end
    else begin
      nvec++;
      if (obs_q[0] !== {32'hFFFF_FFFC, 32'hEF00_0000, 4'b1000}) begin
        nfail++; $display("FAIL wrap_beat0: got %h want %h", obs_q[0], {32'hFFFF_FFFC, 32'hEF00_0000, 4'b1000});
      end
      nvec++;
      if (obs_q[1] !== {32'h0, 32'h0000_00BE, 4'b0001}) begin
        nfail++; $display("FAIL wrap_beat1: got %h want %h", obs_q[1], {32'h0, 32'h0000_00BE, 4'b0001});
      end
    end
    nvec++;
    if (done_cyc !== 3) begin nfail++; $display("FAIL wrap_done: got %0d want 3", done_cyc); end
  endtask

  task automatic test_backpressure();
    int extra;
    test_misaligned_word(3, 1);
    nvec++;
    if (stable_ok !== 1'b1) begin nfail++; $display("FAIL bp_stable: got %b want 1", stable_ok); end
    nvec++;
    if (rdy_low_ok !== 1'b1) begin nfail++; $display("FAIL bp_req_ready_low: got %b want 1", rdy_low_ok); end
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (mem_valid) extra++;
    end
    nvec++;
    if (extra !== 0) begin nfail++; $display("FAIL bp_injected_ignored: got %0d beats want 0", extra); end
  endtask

  task automatic test_illegal();
    int nerr, nmv, ndone;
    req_valid = 1; req_size = 2'b11; req_addr = 32'h40; req_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_valid = 0; req_size = 2'b00;
    nvec++;
    if ({err, req_ready, mem_valid, done} !== 4'b1100) begin
      nfail++; $display("FAIL illegal_pulse: got err/rdy/mv/done %b want 1100", {err, req_ready, mem_valid, done});
    end
    nerr = 0; nmv = 0; ndone = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1;
      @(posedge clk); #1;
      nerr += int'(err); nmv += int'(mem_valid); ndone += int'(done);
    end
    mem_ready = 0;
    nvec++;
    if (nerr !== 0 || nmv !== 0 || ndone !== 0) begin
      nfail++; $display("FAIL illegal_after: got err %0d mv %0d done %0d want 0 0 0", nerr, nmv, ndone);
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    req_valid = 1; req_size = 2'b10; req_addr = 32'h301; req_data = 32'h1122_3344;
    @(posedge clk); #1;
    req_valid = 0; mem_ready = 1;
    @(posedge clk); #1;
    mem_ready = 0;
    nvec++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h304) begin
      nfail++; $display("FAIL rmid_beat1: got mv %b addr %h want 1 00000304", mem_valid, mem_addr);
    end
    #2 reset = 1;
    #1;
    nvec++;
    if (mem_valid !== 1'b0 || req_ready !== 1'b0) begin
      nfail++; $display("FAIL rmid_async: got mv %b rdy %b want 0 0", mem_valid, req_ready);
    end
    @(posedge clk);
    @(negedge clk); reset = 0;
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1;
      @(posedge clk); #1;
      ndone += int'(done) + int'(mem_valid);
    end
    mem_ready = 0;
    nvec++;
    if (ndone !== 0 || req_ready !== 1'b1) begin
      nfail++; $display("FAIL rmid_after: got done+mv %0d rdy %b want 0 1", ndone, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    run_store(32'h12, 2'b10, 32'h8765_4321, 0, 0);
    nvec++;
    if (done_cyc !== 3) begin nfail++; $display("FAIL b2b_first_done: got %0d want 3", done_cyc); end
    d = $urandom;
    model(32'h22, 2'b01, d);
    run_store(32'h22, 2'b01, d, 0, 0);
    nvec++;
    if (wait_cyc !== 0 || first_beat_cyc !== 1) begin
      nfail++; $display("FAIL b2b_accept: got wait %0d first beat %0d want 0 1", wait_cyc, first_beat_cyc);
    end
    nvec++;
    if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
      nfail++; $display("FAIL b2b_beat: got %h want %h", obs_q[0], exp_q[0]);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [1:0] sz;
    int stall;
    for (int it = 0; it < 40; it++) begin
      a = $urandom; d = $urandom;
      sz = 2'($urandom_range(0, 2));
      stall = $urandom_range(0, 2);
      model(a, sz, d);
      run_store(a, sz, d, stall, 1'($urandom_range(0, 1)));
      nvec++;
      if (obs_q.size() !== exp_q.size()) begin
        nfail++; $display("FAIL rand_nbeats: a=%h sz=%0d got %0d want %0d", a, sz, obs_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          nvec++;
          if (obs_q[i] !== exp_q[i]) begin
            nfail++; $display("FAIL rand_beat%0d: a=%h sz=%0d d=%h got %h want %h", i, a, sz, d, obs_q[i], exp_q[i]);
          end
        end
      end
      nvec++;
      if (done_cyc !== 1 + stall + exp_q.size() || err_cnt !== 0) begin
        nfail++; $display("FAIL rand_done: got cycle %0d err %0d want cycle %0d err 0", done_cyc, err_cnt, 1 + stall + exp_q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_half();
    test_misaligned_word(0, 0);
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/store_align_unit.md
# store_align_unit

Store-side byte-lane aligner for the MIPS data-memory path, the write-direction counterpart of the load-side sign/zero extension. It takes a register value plus access size and byte address, narrows and shifts the data onto the correct byte lanes of a 32-bit little-endian memory word, and generates byte enables. A misaligned halfword or word that crosses a word boundary is split into two sequential memory beats. Each request and each memory beat uses a valid/ready handshake.

## Interface
- No parameters; address and data are fixed at 32 bits.

- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  store request present
- req_ready  out  1  unit can accept a request; high only in IDLE and not in reset
- req_addr  in  32  byte address of the store
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_data  in  32  store data, right-justified; only the low 1, 2 or 4 bytes are used
- mem_valid  out  1  memory beat present
- mem_ready  in  1  memory accepts the beat
- mem_addr  out  32  word-aligned beat address (bits [1:0] = 00)
- mem_wdata  out  32  lane-aligned write data; disabled lanes are driven to 0
- mem_be  out  4  byte enables; bit i enables lane [8i+7:8i]
- done  out  1  one-cycle pulse: the store completed
- err  out  1  one-cycle pulse: illegal size was rejected

## Operation
- States: IDLE, BEAT0, BEAT1.
- **Accept:** a request is accepted on a rising edge when req_valid and req_ready are both high.
- **Lane computation** at accept time:
  - o = req_addr[1:0].
  - n = 1, 2 or 4 bytes, from req_size.
  - W64 = zero-extended low n bytes of req_data, shifted left by 8·o.
  - BE8 = ((1<<n)−1)<<o.
  - Base = req_addr with bits [1:0] cleared.
- **Beat 0:** mem_addr = base, mem_wdata = W64[31:0], mem_be = BE8[3:0].
- **Beat 1:** exists only if BE8[7:4] ≠ 0. mem_addr = base+4 modulo 2^32, mem_wdata = W64[63:32], mem_be = BE8[7:4].
- **Transitions:**
  - IDLE→BEAT0 on a legal accept.
  - BEAT0→BEAT1 on a beat-0 handshake when beat 1 exists; otherwise BEAT0→IDLE.
  - BEAT1→IDLE on a beat-1 handshake.
- **Illegal size (11):** the request is accepted and stays in IDLE. err pulses the next cycle. No memory beat is issued and done is not asserted.
- **Misalignment is not an error.** Crossing cases:
  - word with o ≠ 0
  - halfword with o = 3
- All request fields are latched at accept; later changes on the req_* inputs have no effect on the operation in progress.
- **Reset:**
  - state = IDLE
  - mem_valid, mem_addr, mem_wdata, mem_be, done and err = 0
  - req_ready = 0 while reset is high
  - Reset mid-operation discards the operation immediately: mem_valid drops asynchronously and no done pulse follows.

## Timing
- mem_* outputs, done and err are registered. req_ready is decoded from the state.
- **Aligned or non-crossing store:**
  - accept at edge 0
  - mem_valid high in cycle 1
  - if mem_ready is high, handshake at edge 1
  - done high in cycle 2 (state is IDLE, req_ready high)
- **Crossing store:** beat 1 is valid in the cycle after the beat-0 handshake. With no backpressure, done is high in cycle 3.
- **Backpressure:** while mem_valid is high and mem_ready is low, mem_addr, mem_wdata and mem_be hold stable and mem_valid stays high.
- **Back-to-back:** a new request may be accepted in the same cycle done is high. Its beat 0 appears in the following cycle.
- **Minimum throughput:** one store per 2 cycles (non-crossing) or 3 cycles (crossing).
- **err timing:** err is high the cycle after an illegal accept, with req_ready high again in that cycle.

## Test plan
- **Byte store, non-crossing:** byte, addr 0x103, data 0x000000A5, mem_ready = 1 → one beat: addr 0x100, wdata 0xA5000000, be 1000; done in cycle 2.
- **Halfword store, non-crossing:** halfword, addr 0x202, data 0x1234ABCD → one beat: addr 0x200, wdata 0xABCD0000, be 1100; done.
- **Misaligned word:** word, addr 0x301, data 0x11223344 →
  - beat 0: addr 0x300, wdata 0x22334400, be 1110
  - beat 1: addr 0x304, wdata 0x00000011, be 0001
  - done in cycle 3
- **Address wrap:** halfword, addr 0xFFFFFFFF, data 0x0000BEEF →
  - beat 0: addr 0xFFFFFFFC, wdata 0xEF000000, be 1000
  - beat 1: addr 0x00000000, wdata 0x000000BE, be 0001
- **Backpressure:** mem_ready held low 3 cycles during beat 0 of the word at 0x301 → beat fields stable; req_ready = 0; a req_valid pulse with other data is ignored; the beat sequence completes unchanged after mem_ready rises.
- **Illegal size, then reset:**
  - req_size 11 → err pulses once; mem_valid never rises; done stays 0.
  - Then reset asserted during beat 1 of a crossing store → mem_valid = 0 immediately; no done pulse; req_ready = 1 after reset is released.
